// File: rtl/defuzz_centroid.sv
// Sequential centroid defuzzifier: accumulates sum(mu*x) and sum(mu) per frame, then divides bit-serially.
// Optional build macro DEFUZZ_ROUND_EN: round the magnitude half away from zero instead of truncating.
module defuzz_centroid #(
   parameter int MAX_N = 256,
   parameter int LOG2N = $clog2(MAX_N),
   parameter int NUM_W = 24 + LOG2N,
   parameter int DEN_W = 15 + LOG2N
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic signed [7:0] in_x,
   input  logic [15:0]       in_mu,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_y,
   output logic              out_empty,
   output logic              out_ovf
);

   localparam int CNT_W  = LOG2N + 1;
   localparam int STEP_W = $clog2(NUM_W + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_N);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_W);
   localparam logic [NUM_W:0]    NEG_LIM   = (NUM_W+1)'(128);
   localparam logic [NUM_W:0]    POS_LIM   = (NUM_W+1)'(127);

   typedef enum logic [1:0] {ACC, DIV, FIN, OUT} state_t;

   state_t state, state_next;

   logic signed [NUM_W-1:0] num;
   logic [DEN_W-1:0]        den;
   logic [CNT_W-1:0]        cnt;
   logic                    ovf;
   logic [NUM_W-1:0]        quot;
   logic [DEN_W-1:0]        rem;
   logic [STEP_W-1:0]       step;
   logic                    neg;

   logic [15:0]             mu_sat;
   logic signed [23:0]      mu_s;
   logic signed [23:0]      x_s;
   logic signed [23:0]      prod;
   logic [NUM_W-1:0]        num_abs;
   logic [DEN_W:0]          trial;
   logic [DEN_W:0]          diff;
   logic                    ge;
   logic [NUM_W:0]          mag;
   logic [7:0]              y_fin;
   logic                    accept;

   // Q1.15 membership never goes negative: bit15 saturates to full membership.
   assign mu_sat  = in_mu[15] ? 16'h7FFF : in_mu;
   assign mu_s    = {8'd0, mu_sat};
   assign x_s     = {{16{in_x[7]}}, in_x};
   assign prod    = mu_s * x_s;
   assign accept  = in_valid & in_ready;
   assign num_abs = num[NUM_W-1] ? NUM_W'(-num) : NUM_W'(num);

   assign trial = {rem, quot[NUM_W-1]};
   assign diff  = trial - {1'b0, den};
   assign ge    = (trial >= {1'b0, den});

   always_comb begin
      mag = {1'b0, quot};
`ifdef DEFUZZ_ROUND_EN
      if ({rem, 1'b0} >= {1'b0, den})
         mag = mag + (NUM_W+1)'(1);
`endif
      if (neg)
         y_fin = (mag > NEG_LIM) ? 8'h80 : (~mag[7:0] + 8'd1);
      else
         y_fin = (mag > POS_LIM) ? 8'h7F : mag[7:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= ACC;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         ACC: begin
            in_ready = 1'b1;
            if (in_valid && in_last)
               state_next = DIV;
         end
         DIV: begin
            if (step == STEP_LAST)
               state_next = FIN;
         end
         FIN: state_next = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (out_ready)
               state_next = ACC;
         end
         default: state_next = ACC;
      endcase
   end

   // First DIV cycle latches |num|; each later DIV cycle retires one quotient bit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         num       <= '0;
         den       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         quot      <= '0;
         rem       <= '0;
         step      <= '0;
         neg       <= 1'b0;
         out_y     <= '0;
         out_empty <= 1'b0;
         out_ovf   <= 1'b0;
      end else begin
         case (state)
            ACC: begin
               step <= '0;
               if (accept) begin
                  if (cnt < CNT_MAX) begin
                     num <= num + {{(NUM_W-24){prod[23]}}, prod};
                     den <= den + {{(DEN_W-16){1'b0}}, mu_sat};
                     cnt <= cnt + CNT_W'(1);
                  end else begin
                     ovf <= 1'b1;
                  end
               end
            end
            DIV: begin
               step <= step + STEP_W'(1);
               if (step == '0) begin
                  neg  <= num[NUM_W-1];
                  quot <= num_abs;
                  rem  <= '0;
               end else begin
                  quot <= {quot[NUM_W-2:0], ge};
                  rem  <= ge ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
               end
            end
            FIN: begin
               out_y     <= (den == '0) ? 8'd0 : y_fin;
               out_empty <= (den == '0);
               out_ovf   <= ovf;
            end
            OUT: begin
               if (out_ready) begin
                  num       <= '0;
                  den       <= '0;
                  cnt       <= '0;
                  ovf       <= 1'b0;
                  step      <= '0;
                  out_y     <= '0;
                  out_empty <= 1'b0;
                  out_ovf   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_defuzz_centroid.sv
// Scoreboard bench for defuzz_centroid: randomized frames against an arithmetic centroid model.
// Honours DEFUZZ_ROUND_EN the same way as the design build.
module tb_defuzz_centroid;

   localparam int MAX_N = 256;
   localparam int NUM_W = 32;

   typedef struct {
      int y;
      int empty;
      int ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_x = '0;
   logic [15:0] in_mu = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_y;
   logic        out_empty;
   logic        out_ovf;

   int   checks = 0;
   int   failures = 0;
   int   ready_mode = 0;
   exp_t sb[$];
   exp_t mon_e;
   int   fx[$];
   int   fmu[$];

   always #5 clk = ~clk;

   defuzz_centroid #(.MAX_N(MAX_N)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_mu(in_mu), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
      .out_empty(out_empty), .out_ovf(out_ovf)
   );

   task automatic check_output(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp_v);
      end
   endtask

   // Centroid straight from the definition: weighted mean of the first MAX_N samples.
   function automatic exp_t model();
      longint num = 0, den = 0, mag, rem, a, m;
      exp_t   e;
      for (int i = 0; i < fx.size(); i++) begin
         if (i < MAX_N) begin
            m = (fmu[i] > 32767) ? 32767 : fmu[i];
            num += m * fx[i];
            den += m;
         end
      end
      e.ovf = (fx.size() > MAX_N) ? 1 : 0;
      if (den == 0) begin
         e.y = 0;
         e.empty = 1;
      end else begin
         a = (num < 0) ? -num : num;
         mag = a / den;
         rem = a % den;
`ifdef DEFUZZ_ROUND_EN
         if (2 * rem >= den) mag++;
`endif
         e.empty = 0;
         if (num < 0) e.y = (mag > 128) ? -128 : -int'(mag);
         else         e.y = (mag > 127) ? 127 : int'(mag);
      end
      return e;
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #2;
         out_ready = (ready_mode == 2) || (ready_mode == 0 && $urandom_range(0, 3) != 0);
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check_output("unexpected_output", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check_output("out_y", int'($signed(out_y)), mon_e.y);
            check_output("out_empty", int'(out_empty), mon_e.empty);
            check_output("out_ovf", int'(out_ovf), mon_e.ovf);
         end
      end
   end

   task automatic wait_accept();
      int n = 0;
      bit acc = 1'b0;
      while (!acc && n < 500) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) check_output("accept_timeout", 0, 1);
   endtask

   task automatic apply_stimulus(input bit push, input int gap_max);
      if (push) sb.push_back(model());
      for (int i = 0; i < fx.size(); i++) begin
         if (i != 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
         in_valid = 1'b1;
         in_x     = 8'(fx[i]);
         in_mu    = 16'(fmu[i]);
         in_last  = (i == fx.size() - 1);
         wait_accept();
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   task automatic measure_latency();
      int n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_output("latency", n, NUM_W + 2);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_output("drain", sb.size(), 0);
   endtask

   task automatic check_reset_state(input string tag);
      check_output({tag, "_in_ready"}, int'(in_ready), 1);
      check_output({tag, "_out_valid"}, int'(out_valid), 0);
      check_output({tag, "_out_y"}, int'(out_y), 0);
      check_output({tag, "_out_empty"}, int'(out_empty), 0);
      check_output({tag, "_out_ovf"}, int'(out_ovf), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_reset_state("reset");

      fx = '{40};                fmu = '{32'h7FFF};
      apply_stimulus(1'b1, 0);
      measure_latency();
      wait_idle();

      fx = '{-100, 100};         fmu = '{32'h7FFF, 32'h7FFF};
      apply_stimulus(1'b1, 1);   wait_idle();
      fx = '{10, 20};            fmu = '{32'h4000, 32'h2000};
      apply_stimulus(1'b1, 1);   wait_idle();
      fx = '{1, 2};              fmu = '{32'h2000, 32'h2000};
      apply_stimulus(1'b1, 1);   wait_idle();
      fx = '{-1, -2};            fmu = '{32'h2000, 32'h2000};
      apply_stimulus(1'b1, 1);   wait_idle();
      fx = '{-128, -128};        fmu = '{32'h7FFF, 32'hFFFF};
      apply_stimulus(1'b1, 0);   wait_idle();
      fx = '{127, 127, 127};     fmu = '{32'h8000, 32'h1234, 32'h7FFF};
      apply_stimulus(1'b1, 0);   wait_idle();

      // Empty frame held under backpressure, then released.
      ready_mode = 1;
      fx = '{10, 20, 30};        fmu = '{0, 0, 0};
      apply_stimulus(1'b1, 1);
      measure_latency();
      repeat (10) begin
         @(posedge clk);
         #1;
         check_output("hold_out_valid", int'(out_valid), 1);
         check_output("hold_out_y", int'(out_y), 0);
         check_output("hold_out_empty", int'(out_empty), 1);
         check_output("hold_in_ready", int'(in_ready), 0);
      end
      ready_mode = 2;
      @(posedge clk);
      #1;
      check_output("release_in_ready", int'(in_ready), 1);
      check_output("release_out_valid", int'(out_valid), 0);
      ready_mode = 0;
      wait_idle();

      // Reset while dividing discards the frame.
      fx = '{7};                 fmu = '{32'h7FFF};
      apply_stimulus(1'b0, 0);
      repeat (5) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_reset_state("middiv");
      fx = '{5};                 fmu = '{32'h7FFF};
      apply_stimulus(1'b1, 0);
      wait_idle();

      // Exactly MAX_N samples, then one sample beyond.
      for (int len = MAX_N; len <= MAX_N + 1; len++) begin
         fx.delete();
         fmu.delete();
         for (int i = 0; i < len; i++) begin
            fx.push_back(int'($urandom_range(0, 255)) - 128);
            fmu.push_back(int'($urandom_range(0, 65535)));
         end
         apply_stimulus(1'b1, 0);
         wait_idle();
      end

      repeat (40) begin
         fx.delete();
         fmu.delete();
         repeat ($urandom_range(1, 8)) begin
            int r;
            r = int'($urandom_range(0, 9));
            fx.push_back(int'($urandom_range(0, 255)) - 128);
            if (r == 0)      fmu.push_back(0);
            else if (r == 1) fmu.push_back(int'($urandom_range(32768, 65535)));
            else             fmu.push_back(int'($urandom_range(0, 32767)));
         end
         apply_stimulus(1'b1, 2);
      end
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
